weight_lb_loader: RTL and testbench

- Weight fetch stage directly upstream of the vector-core weight register.
- Reads 128b weight beats from the line buffer (LB) with credit-based flow control and buffers them in a small FIFO.
- Drives weight_wr_vld / LB_data_out beat-by-beat into the weight register, one group at a time.
- Holds each loaded group until the compute side consumes it, while prefetching the next group's beats into the FIFO.

---
 rtl/vc_pkg.sv | 32 +++
 rtl/weight_beat_fifo.sv | 56 +++++
 rtl/weight_lb_loader.sv | 175 +++++++++++++++++
 tb/tb_weight_lb_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pkg.sv
// Shared vector-core definitions: calc_mode encodings, beat width and the
// beats-per-group rule used by the weight fetch path.
package vc_pkg;

    localparam int unsigned BEAT_W = 128;

    localparam logic [2:0] CALC_CONV    = 3'b000;
    localparam logic [2:0] CALC_SPARSE  = 3'b001;
    localparam logic [2:0] CALC_DW      = 3'b010;
    localparam logic [2:0] CALC_FC      = 3'b011;
    localparam logic [2:0] CALC_DENSE_X = 3'b100;
    localparam logic [2:0] CALC_DW_X    = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } ld_state_e;

    // Number of 128b beats making up one weight group (1..4).
    function automatic logic [2:0] beats_per_group(input logic [2:0] mode, input logic dbl);
        logic [2:0] b;
        case (mode)
            CALC_CONV, CALC_FC, CALC_DENSE_X: b = 3'd1;
            CALC_SPARSE:                      b = 3'd3;
            CALC_DW, CALC_DW_X:               b = dbl ? 3'd4 : 3'd2;
            default:                          b = 3'd1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/weight_beat_fifo.sv
// Small synchronous FIFO holding LB beats between read return and the weight
// register write. Flush has priority over push/pop.
module weight_beat_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/weight_lb_loader.sv
// Weight fetch stage: credit-limited LB reads into a beat FIFO, then group-wise
// writes into the weight register, holding each group until compute consumes it.
module weight_lb_loader
    import vc_pkg::*;
#(
    parameter int unsigned LB_AW      = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GRP_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        cfg_calc_mode,
    input  logic              cfg_double_byte,
    input  logic [LB_AW-1:0]  cfg_base_addr,
    input  logic [GRP_W-1:0]  cfg_group_num,
    output logic              lb_rd_en,
    output logic [LB_AW-1:0]  lb_rd_addr,
    input  logic              lb_rd_data_vld,
    input  logic [BEAT_W-1:0] lb_rd_data,
    output logic              weight_wr_vld,
    output logic [1:0]        weight_reg_wr_cnt,
    output logic [BEAT_W-1:0] LB_data_out,
    input  logic              weight_wr_done,
    input  logic              weight_consume,
    output logic              weight_ready,
    output logic              busy,
    output logic              done,
    output logic              err_sync
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TOT_W = GRP_W + 2;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    ld_state_e        r_state;
    ld_state_e        w_state_nxt;
    logic [1:0]       r_bm1;
    logic [TOT_W-1:0] r_total;
    logic [TOT_W-1:0] r_issued;
    logic [LB_AW-1:0] r_base;
    logic [GRP_W-1:0] r_groups;
    logic [GRP_W-1:0] r_grp_used;
    logic [CW-1:0]    r_outstanding;
    logic [1:0]       r_wr_beat;
    logic             r_grp_loaded;
    logic             r_err;

    logic [2:0]        w_beats;
    logic              w_run;
    logic              w_start_ok;
    logic              w_consume;
    logic              w_last_beat;
    logic              w_credit_ok;
    logic              w_fifo_push;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [BEAT_W-1:0] w_fifo_rdata;

    assign w_beats     = beats_per_group(cfg_calc_mode, cfg_double_byte);
    assign w_run       = (r_state == StRun);
    assign w_start_ok  = start & ~abort & (r_state == StIdle) & (r_outstanding == '0);
    assign w_consume   = w_run & weight_consume & r_grp_loaded;
    assign w_last_beat = (r_wr_beat == r_bm1);

    // Reads in flight plus beats already buffered may never exceed the FIFO.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < CREDIT_MAX;

    assign lb_rd_en          = w_run & (r_issued < r_total) & w_credit_ok;
    assign lb_rd_addr        = r_base + LB_AW'(r_issued);
    assign weight_wr_vld     = w_run & ~w_fifo_empty & ~r_grp_loaded;
    assign LB_data_out       = w_fifo_empty ? '0 : w_fifo_rdata;
    assign weight_reg_wr_cnt = r_bm1;
    assign weight_ready      = r_grp_loaded;
    assign busy              = (r_state != StIdle) | (r_outstanding != '0);
    assign done              = (r_state == StDone);
    assign err_sync          = r_err;

    // Words returning outside RUN belong to an aborted layer and are dropped.
    assign w_fifo_push = lb_rd_data_vld & w_run;

    weight_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BEAT_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_fifo_push),
        .i_wdata (lb_rd_data),
        .i_pop   (weight_wr_vld),
        .i_flush (abort),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_start_ok) w_state_nxt = (cfg_group_num == '0) ? StDone : StRun;
                end
                StRun: begin
                    if (w_consume && ((r_grp_used + GRP_W'(1)) == r_groups)) w_state_nxt = StDone;
                end
                StDone:  w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= StIdle;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bm1         <= '0;
            r_total       <= '0;
            r_issued      <= '0;
            r_base        <= '0;
            r_groups      <= '0;
            r_grp_used    <= '0;
            r_outstanding <= '0;
            r_wr_beat     <= '0;
            r_grp_loaded  <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // Outstanding keeps draining across abort so busy covers late returns.
            r_outstanding <= r_outstanding + CW'(lb_rd_en) - CW'(lb_rd_data_vld);

            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (weight_wr_done != (weight_wr_vld & w_last_beat)) begin
                r_err <= 1'b1;
            end

            if (abort) begin
                r_issued     <= '0;
                r_wr_beat    <= '0;
                r_grp_loaded <= 1'b0;
                r_grp_used   <= '0;
            end else if (w_start_ok) begin
                r_bm1        <= 2'(w_beats - 3'd1);
                r_total      <= TOT_W'(cfg_group_num) * TOT_W'(w_beats);
                r_base       <= cfg_base_addr;
                r_groups     <= cfg_group_num;
                r_issued     <= '0;
                r_wr_beat    <= '0;
                r_grp_loaded <= 1'b0;
                r_grp_used   <= '0;
            end else begin
                if (lb_rd_en) r_issued <= r_issued + 1'b1;
                if (weight_wr_vld) begin
                    if (w_last_beat) begin
                        r_wr_beat    <= '0;
                        r_grp_loaded <= 1'b1;
                    end else begin
                        r_wr_beat <= r_wr_beat + 1'b1;
                    end
                end
                if (w_consume) begin
                    r_grp_loaded <= 1'b0;
                    r_grp_used   <= r_grp_used + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_weight_lb_loader.sv
// Directed bench for weight_lb_loader: LB latency model, weight register model,
// per-cycle comparison against a queue-based reference, plus literal checks.
module tb_weight_lb_loader;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [2:0]   cfg_calc_mode = '0;
    logic         cfg_double_byte = 1'b0;
    logic [11:0]  cfg_base_addr = '0;
    logic [15:0]  cfg_group_num = '0;
    logic         lb_rd_en;
    logic [11:0]  lb_rd_addr;
    logic         lb_rd_data_vld = 1'b0;
    logic [127:0] lb_rd_data = '0;
    logic         weight_wr_vld;
    logic [1:0]   weight_reg_wr_cnt;
    logic [127:0] LB_data_out;
    logic         weight_wr_done = 1'b0;
    logic         weight_consume = 1'b0;
    logic         weight_ready;
    logic         busy;
    logic         done;
    logic         err_sync;

    always #5 clk = ~clk;

    weight_lb_loader #(
        .LB_AW      (12),
        .FIFO_DEPTH (4),
        .GRP_W      (16)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .start             (start),
        .abort             (abort),
        .cfg_calc_mode     (cfg_calc_mode),
        .cfg_double_byte   (cfg_double_byte),
        .cfg_base_addr     (cfg_base_addr),
        .cfg_group_num     (cfg_group_num),
        .lb_rd_en          (lb_rd_en),
        .lb_rd_addr        (lb_rd_addr),
        .lb_rd_data_vld    (lb_rd_data_vld),
        .lb_rd_data        (lb_rd_data),
        .weight_wr_vld     (weight_wr_vld),
        .weight_reg_wr_cnt (weight_reg_wr_cnt),
        .LB_data_out       (LB_data_out),
        .weight_wr_done    (weight_wr_done),
        .weight_consume    (weight_consume),
        .weight_ready      (weight_ready),
        .busy              (busy),
        .done              (done),
        .err_sync          (err_sync)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lat = 2;
    bit auto_cons = 1'b0;
    bit inject = 1'b0;

    typedef struct {
        int         due;
        logic [11:0] addr;
    } rd_t;
    rd_t lbq[$];

    // Reference state
    int m_st = 0;
    int m_b = 1;
    int m_t = 0;
    int m_groups = 0;
    int m_base = 0;
    int m_issued = 0;
    int m_out = 0;
    int m_beat = 0;
    int m_used = 0;
    bit m_loaded = 1'b0;
    bit m_err = 1'b0;
    logic [127:0] m_fifo[$];

    // Observed statistics
    int n_rden, n_wvld, n_done, done_cyc, cons_cyc, start_cyc;
    int rdc[$];
    int wvc[$];
    logic [11:0] addrq[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] word_of(input logic [11:0] a);
        return {8{a, 4'h5}} ^ {96'h0, 20'h0, ~a};
    endfunction

    function automatic int beats(input logic [2:0] mode, input logic db);
        if (mode == 3'd1) return 3;
        if (mode == 3'd2 || mode == 3'd5) return db ? 4 : 2;
        return 1;
    endfunction

    // LB: fixed-latency return of each issued read
    always @(posedge clk) begin
        cyc++;
        #1;
        if (lbq.size() > 0 && lbq[0].due == cyc) begin
            lb_rd_data_vld = 1'b1;
            lb_rd_data     = word_of(lbq[0].addr);
            void'(lbq.pop_front());
        end else begin
            lb_rd_data_vld = 1'b0;
            lb_rd_data     = '0;
        end
    end

    // Weight register: flags its last beat (or beat 1 when injecting a fault)
    always @(posedge clk) begin
        #2;
        weight_wr_done = weight_wr_vld && (m_beat == (inject ? 1 : m_b - 1));
    end

    always @(posedge clk) begin
        #1;
        weight_consume = auto_cons && weight_ready;
    end

    always @(negedge clk) begin
        bit e_rden, e_wvld, e_last, lb_before, start_ok;
        rd_t r;
        if (!rstn) begin
            m_st = 0; m_b = 1; m_t = 0; m_groups = 0; m_base = 0; m_issued = 0;
            m_out = 0; m_beat = 0; m_used = 0; m_loaded = 0; m_err = 0;
            m_fifo.delete();
        end else begin
            e_rden = (m_st == 1) && (m_issued < m_t) && (m_out + m_fifo.size() < 4);
            e_wvld = (m_st == 1) && (m_fifo.size() > 0) && !m_loaded;
            chk("rd_en", int'(lb_rd_en), int'(e_rden));
            if (e_rden) chk("rd_addr", int'(lb_rd_addr), (m_base + m_issued) % 4096);
            chk("wr_vld", int'(weight_wr_vld), int'(e_wvld));
            if (e_wvld) chk_w("wr_data", LB_data_out, m_fifo[0]);
            chk("wr_cnt", int'(weight_reg_wr_cnt), m_b - 1);
            chk("ready", int'(weight_ready), int'(m_loaded));
            chk("busy", int'(busy), int'(m_st != 0 || m_out > 0));
            chk("done", int'(done), int'(m_st == 2));
            chk("err", int'(err_sync), int'(m_err));

            if (lb_rd_en) begin
                n_rden++;
                rdc.push_back(cyc);
                addrq.push_back(lb_rd_addr);
                r.due  = cyc + lat;
                r.addr = lb_rd_addr;
                lbq.push_back(r);
            end
            if (weight_wr_vld) begin n_wvld++; wvc.push_back(cyc); end
            if (done) begin n_done++; done_cyc = cyc; end
            if (weight_consume && weight_ready) cons_cyc = cyc;
            if (start) start_cyc = cyc;

            e_last    = (m_beat == m_b - 1);
            lb_before = m_loaded;
            start_ok  = start && !abort && m_st == 0 && m_out == 0;
            if (start_ok) m_err = 1'b0;
            else if (weight_wr_done != (e_wvld && e_last)) m_err = 1'b1;
            m_out = m_out + int'(e_rden) - int'(lb_rd_data_vld);
            if (abort) begin
                m_st = 0; m_fifo.delete(); m_loaded = 0; m_beat = 0; m_issued = 0; m_used = 0;
            end else begin
                if (e_wvld) begin
                    void'(m_fifo.pop_front());
                    if (e_last) begin m_loaded = 1'b1; m_beat = 0; end
                    else m_beat++;
                end
                if (lb_rd_data_vld && m_st == 1) m_fifo.push_back(lb_rd_data);
                if (e_rden) m_issued++;
                case (m_st)
                    0: if (start_ok) begin
                        m_b = beats(cfg_calc_mode, cfg_double_byte);
                        m_groups = int'(cfg_group_num);
                        m_t = m_groups * m_b;
                        m_base = int'(cfg_base_addr);
                        m_issued = 0; m_used = 0; m_beat = 0; m_loaded = 0;
                        m_st = (m_groups == 0) ? 2 : 1;
                    end
                    1: if (weight_consume && lb_before) begin
                        m_loaded = 1'b0;
                        m_used++;
                        if (m_used == m_groups) m_st = 2;
                    end
                    default: m_st = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_rden = 0; n_wvld = 0; n_done = 0; done_cyc = -100; cons_cyc = -100; start_cyc = -100;
        rdc.delete(); wvc.delete(); addrq.delete();
    endtask

    task automatic run_start(input logic [2:0] mode, input logic db, input logic [11:0] base,
                             input logic [15:0] groups);
        cfg_calc_mode = mode; cfg_double_byte = db; cfg_base_addr = base; cfg_group_num = groups;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (n_done == 0 && k < 300) begin step(); k++; end
        chk(name, int'(n_done > 0), 1);
        repeat (2) step();
    endtask

    initial begin
        int k;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", int'(lb_rd_en), 0);
        chk("rst_wr_vld", int'(weight_wr_vld), 0);
        chk("rst_ready", int'(weight_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_sync), 0);
        chk("rst_cnt", int'(weight_reg_wr_cnt), 0);
        chk_w("rst_data", LB_data_out, '0);
        rstn = 1'b1;
        step();

        // Conv, 3 groups of 1 beat
        lat = 2; clr(); auto_cons = 1;
        run_start(3'b000, 1'b0, 12'h010, 16'd3);
        wait_done("t1_done");
        chk("t1_nrd", n_rden, 3);
        chk("t1_addr0", int'(addrq[0]), 'h010);
        chk("t1_addr2", int'(addrq[2]), 'h012);
        chk("t1_latency", wvc[0] - rdc[0], 3);
        chk("t1_nwr", n_wvld, 3);
        chk("t1_done_after_cons", done_cyc - cons_cyc, 1);
        chk("t1_ndone", n_done, 1);

        // Sparse, consume withheld
        clr(); auto_cons = 0;
        run_start(3'b001, 1'b0, 12'h100, 16'd2);
        repeat (30) step();
        chk("t2_wr_held", n_wvld, 3);
        chk("t2_nrd", n_rden, 6);
        chk("t2_ready", int'(weight_ready), 1);
        chk("t2_cnt", int'(weight_reg_wr_cnt), 2);
        chk("t2_rd_idle", int'(lb_rd_en), 0);
        auto_cons = 1;
        wait_done("t2_done");
        chk("t2_nwr", n_wvld, 6);
        chk("t2_b2b", wvc[5] - wvc[3], 2);

        // Dwconv int16, latency 3, address wrap
        lat = 3; clr();
        run_start(3'b010, 1'b1, 12'hFFE, 16'd1);
        wait_done("t3_done");
        chk("t3_cnt", int'(weight_reg_wr_cnt), 3);
        chk("t3_rd_burst", rdc[3] - rdc[0], 3);
        chk("t3_wr_burst", wvc[3] - wvc[0], 3);
        chk("t3_latency", wvc[0] - rdc[0], 4);
        chk("t3_addr1", int'(addrq[1]), 'hFFF);
        chk("t3_addr2", int'(addrq[2]), 'h000);

        // Zero groups
        clr();
        run_start(3'b000, 1'b0, 12'h000, 16'd0);
        repeat (3) step();
        chk("t4_nrd", n_rden, 0);
        chk("t4_done_lat", done_cyc - start_cyc, 1);
        chk("t4_ndone", n_done, 1);

        // Abort with reads in flight
        lat = 3; clr(); auto_cons = 0;
        run_start(3'b000, 1'b0, 12'h200, 16'd6);
        k = 0;
        while (!weight_ready && k < 50) begin step(); k++; end
        chk("t5_ready_seen", int'(weight_ready), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_wvld = 0; n_rden = 0; n_done = 0;
        chk("t5_ready_abort", int'(weight_ready), 0);
        chk("t5_busy_abort", int'(busy), 1);
        run_start(3'b001, 1'b0, 12'h3A0, 16'd1);
        chk("t5_start_ignored", int'(weight_reg_wr_cnt), 0);
        k = 0;
        while (busy && k < 30) begin step(); k++; end
        chk("t5_busy_drop", int'(busy), 0);
        chk("t5_no_wr", n_wvld, 0);
        chk("t5_no_rd", n_rden, 0);
        chk("t5_no_done", n_done, 0);
        clr(); auto_cons = 1;
        run_start(3'b000, 1'b0, 12'h300, 16'd1);
        wait_done("t5_rerun_done");
        chk("t5_rerun_addr", int'(addrq[0]), 'h300);
        chk("t5_rerun_nwr", n_wvld, 1);

        // Weight register flags beat 1 of a 3-beat group
        lat = 2; clr(); inject = 1;
        run_start(3'b001, 1'b0, 12'h040, 16'd1);
        wait_done("t6_done");
        chk("t6_err", int'(err_sync), 1);
        inject = 0;
        repeat (3) step();
        chk("t6_err_hold", int'(err_sync), 1);
        run_start(3'b000, 1'b0, 12'h000, 16'd0);
        chk("t6_err_clr", int'(err_sync), 0);
        wait_done("t6_clr_done");

        // Reset mid-operation
        clr(); auto_cons = 0;
        run_start(3'b000, 1'b0, 12'h050, 16'd4);
        repeat (4) step();
        rstn = 1'b0;
        lbq.delete();
        #1;
        chk("t7_busy", int'(busy), 0);
        chk("t7_ready", int'(weight_ready), 0);
        chk("t7_rd_en", int'(lb_rd_en), 0);
        step();
        rstn = 1'b1;
        repeat (4) step();
        chk("t7_no_done", n_done, 0);
        chk("t7_idle", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
